// File: rtl/seri_carpici_if.sv
// Serial link bundle for seri_carpici: receive line, transmit line and status.
interface seri_carpici_if;
    logic rx;
    logic tx;
    logic busy;
    logic done;

    // Link driver / observer side.
    modport master (output rx, input tx, input busy, input done);
    // Multiplier side.
    modport slave  (input rx, output tx, output busy, output done);
endinterface

// File: rtl/seri_carpici.sv
// seri_carpici: bit-serial framed multiplier.
// It receives a start bit and then operands A and B, LSB first.
// It multiplies them with a shift-add engine, one multiplier bit per cycle.
// It then transmits a start bit followed by the 2*WIDTH-bit product, LSB first.
module seri_carpici #(
    parameter int WIDTH  = 3,
    parameter bit SIGNED = 1'b0
) (
    input logic            clk,
    input logic            rst,
    seri_carpici_if.slave  bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(PW + 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RECV = 2'b01,
        ST_MUL  = 2'b10,
        ST_SEND = 2'b11
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [PW-2:0]   r_op;       // operand bits collected so far, oldest at bit 0
    logic [PW-1:0]   r_acc;
    logic [PW-1:0]   r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic            r_neg;
    logic [PW:0]     r_sh;       // start bit at [0], product above it
    logic            r_tx;
    logic            r_busy;
    logic            r_done;

    logic [PW-1:0]    w_op_full;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [PW-1:0]    w_addend;
    logic [PW-1:0]    w_acc_sum;
    logic [PW-1:0]    w_prod;
    logic             w_last_rx;
    logic             w_last_mul;
    logic             w_last_send;

    assign w_last_rx   = (r_cnt == CW'(PW - 1));
    assign w_last_mul  = (r_cnt == CW'(WIDTH - 1));
    assign w_last_send = (r_cnt == CW'(PW + 1));

    // Operand decode on the final receive edge; sign handling and the shift-add step.
    always_comb begin
        w_op_full = {bus.rx, r_op};
        w_a       = w_op_full[WIDTH-1:0];
        w_b       = w_op_full[PW-1:WIDTH];
        w_a_neg   = SIGNED && w_a[WIDTH-1];
        w_b_neg   = SIGNED && w_b[WIDTH-1];
        // The most negative value maps onto its own bit pattern, which is the correct unsigned magnitude.
        w_a_mag   = w_a_neg ? (~w_a + WIDTH'(1)) : w_a;
        w_b_mag   = w_b_neg ? (~w_b + WIDTH'(1)) : w_b;
        w_addend  = r_mplier[0] ? r_mcand : {PW{1'b0}};
        w_acc_sum = r_acc + w_addend;
        w_prod    = r_neg ? (~w_acc_sum + PW'(1)) : w_acc_sum;
    end

    // Next-state selection for the receive/multiply/send sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.rx) w_state_next = ST_RECV;
                else        w_state_next = ST_IDLE;
            end
            ST_RECV: begin
                if (w_last_rx) w_state_next = ST_MUL;
                else           w_state_next = ST_RECV;
            end
            ST_MUL: begin
                if (w_last_mul) w_state_next = ST_SEND;
                else            w_state_next = ST_MUL;
            end
            ST_SEND: begin
                if (w_last_send) w_state_next = ST_IDLE;
                else             w_state_next = ST_SEND;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register and the busy flag registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != ST_IDLE);
        end
    end

    // Datapath: operand capture, shift-add multiply, and serial product output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_sh     <= '0;
            r_tx     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_tx   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                end
                ST_RECV: begin
                    r_op <= w_op_full[PW-1:1];
                    if (w_last_rx) begin
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_neg    <= w_a_neg ^ w_b_neg;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_MUL: begin
                    r_acc    <= w_acc_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (w_last_mul) begin
                        r_cnt <= '0;
                        r_sh  <= {w_prod, 1'b1};
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_SEND: begin
                    r_sh <= {1'b0, r_sh[PW:1]};
                    if (w_last_send) begin
                        r_cnt  <= '0;
                        r_tx   <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        r_tx  <= r_sh[0];
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.tx   = r_tx;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_seri_carpici.sv
// Bench for seri_carpici: four instances (W3 unsigned, W3 signed, W8 signed, W8 unsigned).
// The reference model tracks each frame by its edge index k counted from the start edge E0.
// It derives tx, busy and done from the frame timing rules and an arithmetic product.
module tb_seri_carpici;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic rx_v [4];
    seri_carpici_if if0 ();
    seri_carpici_if if1 ();
    seri_carpici_if if2 ();
    seri_carpici_if if3 ();
    assign if0.rx = rx_v[0];
    assign if1.rx = rx_v[1];
    assign if2.rx = rx_v[2];
    assign if3.rx = rx_v[3];

    seri_carpici #(.WIDTH(3), .SIGNED(1'b0)) u0 (.clk(clk), .rst(rst), .bus(if0));
    seri_carpici #(.WIDTH(3), .SIGNED(1'b1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    seri_carpici #(.WIDTH(8), .SIGNED(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2));
    seri_carpici #(.WIDTH(8), .SIGNED(1'b0)) u3 (.clk(clk), .rst(rst), .bus(if3));

    logic d_tx [4];
    logic d_busy [4];
    logic d_done [4];
    always_comb begin
        d_tx[0] = if0.tx; d_busy[0] = if0.busy; d_done[0] = if0.done;
        d_tx[1] = if1.tx; d_busy[1] = if1.busy; d_done[1] = if1.done;
        d_tx[2] = if2.tx; d_busy[2] = if2.busy; d_done[2] = if2.done;
        d_tx[3] = if3.tx; d_busy[3] = if3.busy; d_done[3] = if3.done;
    end

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    int mw [4] = '{3, 3, 8, 8};
    bit ms [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int mk [4] = '{-1, -1, -1, -1};
    logic [15:0] mops [4];
    logic [15:0] mprod [4];
    logic e_tx [4];
    logic e_busy [4];
    logic e_done [4];

    // Exact product of two w-bit operands, reduced to 2w bits.
    function automatic logic [15:0] model_prod(int w, bit s, logic [15:0] a, logic [15:0] b);
        longint av, bv, p, m;
        m  = (longint'(1) << w) - 1;
        av = longint'(a) & m;
        bv = longint'(b) & m;
        if (s && (((av >> (w - 1)) & 1) != 0)) av = av - (longint'(1) << w);
        if (s && (((bv >> (w - 1)) & 1) != 0)) bv = bv - (longint'(1) << w);
        p = av * bv;
        return 16'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    // Reference model: advance each frame position and derive expected outputs.
    always @(posedge clk) begin
        int w, k;
        for (int d = 0; d < 4; d++) begin
            w = mw[d];
            if (rst) begin
                mk[d] = -1;
            end else if (mk[d] == -1 || mk[d] == 5 * w + 2) begin
                if (rx_v[d]) begin
                    mk[d] = 0;
                    mops[d] = 16'h0000;
                end else begin
                    mk[d] = -1;
                end
            end else begin
                mk[d] = mk[d] + 1;
                if (mk[d] >= 1 && mk[d] <= 2 * w) mops[d][mk[d] - 1] = rx_v[d];
                if (mk[d] == 2 * w) mprod[d] = model_prod(w, ms[d], mops[d], mops[d] >> w);
            end
            k = mk[d];
            e_busy[d] = (k >= 0) && (k < 5 * w + 2);
            e_done[d] = (k == 5 * w + 2);
            if (k == 3 * w + 1)                        e_tx[d] = 1'b1;
            else if (k >= 3 * w + 2 && k <= 5 * w + 1) e_tx[d] = mprod[d][k - 3 * w - 2];
            else                                       e_tx[d] = 1'b0;
        end
    end

    // Cycle-by-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 4; d++) begin
                checks++;
                if ({d_tx[d], d_busy[d], d_done[d]} !== {e_tx[d], e_busy[d], e_done[d]}) begin
                    errors++;
                    if (errors <= 40)
                        $display("FAIL cycle dut%0d t=%0t tx/busy/done got %b%b%b want %b%b%b",
                                 d, $time, d_tx[d], d_busy[d], d_done[d], e_tx[d], e_busy[d], e_done[d]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, exp);
        end
    endtask

    // Drives start bit, A then B; returns #1 after edge E2W.
    task automatic send(input int d, input logic [15:0] a, input logic [15:0] b);
        rx_v[d] = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < mw[d]; i++) begin rx_v[d] = a[i]; @(posedge clk); #1; end
        for (int i = 0; i < mw[d]; i++) begin rx_v[d] = b[i]; @(posedge clk); #1; end
        rx_v[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(posedge clk); #1;
            if (d_done[d] === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout dut%0d got none want pulse", d);
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_tx",   {15'h0, d_tx[0]},   16'h0);
        check("rst_busy", {15'h0, d_busy[0]}, 16'h0);
        check("rst_done", {15'h0, d_done[0]}, 16'h0);
        repeat (20) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [6:0] v;
        logic dn16;
        for (int d = 0; d < 4; d++) rx_v[d] = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_busy", {15'h0, d_busy[0]}, 16'h0);

        check("pin_5x3",     model_prod(3, 1'b0, 16'd5, 16'd3),       16'd15);
        check("pin_7x7",     model_prod(3, 1'b0, 16'd7, 16'd7),       16'd49);
        check("pin_0x6",     model_prod(3, 1'b0, 16'd0, 16'd6),       16'd0);
        check("pin_m3x2",    model_prod(3, 1'b1, 16'd5, 16'd2),       16'h003A);
        check("pin_m4xm4",   model_prod(3, 1'b1, 16'd4, 16'd4),       16'd16);
        check("pin_m128x127", model_prod(8, 1'b1, 16'h0080, 16'h007F), 16'hC080);
        check("pin_255x255", model_prod(8, 1'b0, 16'h00FF, 16'h00FF), 16'hFE01);

        // A=5, B=3: literal tx stream E10..E16 and done at E17.
        send(0, 16'd5, 16'd3);
        dn16 = 1'b0;
        v = 7'h00;
        for (int e = 7; e <= 17; e++) begin
            @(posedge clk); #1;
            if (e >= 10 && e <= 16) v[e - 10] = d_tx[0];
            if (e == 16) dn16 = d_done[0];
        end
        check("stream_5x3", {9'h0, v}, 16'h001F);
        check("done_e16",   {15'h0, dn16}, 16'h0);
        check("done_e17",   {15'h0, d_done[0]}, 16'h1);
        check("busy_e17",   {15'h0, d_busy[0]}, 16'h0);
        repeat (3) begin @(posedge clk); #1; end

        send(0, 16'd7, 16'd7); wait_done(0);
        send(0, 16'd0, 16'd6); wait_done(0);
        send(1, 16'd5, 16'd2); wait_done(1);
        send(1, 16'd4, 16'd4); wait_done(1);

        // Reset during RECV.
        rx_v[0] = 1'b1;
        @(posedge clk); #1;
        rx_v[0] = 1'b1;
        @(posedge clk); #1;
        rx_v[0] = 1'b0;
        pulse_reset();
        send(0, 16'd6, 16'd5); wait_done(0);

        // Reset during MUL.
        send(0, 16'd3, 16'd3);
        pulse_reset();
        send(0, 16'd2, 16'd7); wait_done(0);

        // Reset during SEND while tx carries P[1] = 1 of 35.
        send(0, 16'd7, 16'd5);
        repeat (6) begin @(posedge clk); #1; end
        check("send_tx_before_rst", {15'h0, d_tx[0]}, 16'h1);
        pulse_reset();
        send(0, 16'd6, 16'd6); wait_done(0);

        // Back-to-back: rx high at E17 (ignored) and E18 (start of next frame).
        send(0, 16'd5, 16'd3);
        repeat (10) begin @(posedge clk); #1; end
        rx_v[0] = 1'b1;
        @(posedge clk); #1;
        check("b2b_done_e17", {15'h0, d_done[0]}, 16'h1);
        send(0, 16'd6, 16'd7); wait_done(0);

        send(2, 16'h0080, 16'h007F); wait_done(2);
        send(3, 16'h00FF, 16'h00FF); wait_done(3);
        send(2, 16'h00FF, 16'h0080); wait_done(2);

        repeat (5) begin @(posedge clk); #1; end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seri_carpici.md
# seri_carpici

Parametrised serial multiply unit, the next-generation replacement for the fixed 3-bit receive–multiply–transmit chain at the top level. It receives a framed pair of WIDTH-bit operands bit-serially on `rx` and multiplies them with an internal shift-add engine. It then transmits the framed 2·WIDTH-bit product bit-serially on `tx`. An explicit FSM with its own bit counter replaces the free-running cycle sequencer, and a signed mode is added.

## Interface
- `WIDTH`, default 3: operand width in bits, ≥2; product width is 2·WIDTH.
- `SIGNED`, default 0: 0 selects unsigned operands and product; 1 selects two's-complement operands and product.
- `clk`  input  1  clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `rx`  input  1  serial input; one bit sampled per clock.
- `tx`  output  1  serial output; registered.
- `busy`  output  1  high whenever state ≠ IDLE.
- `done`  output  1  one-cycle pulse when a product frame has finished.

## Operation
- Line idle level is 0 on both `rx` and `tx`.
- Input frame:
  - start bit 1;
  - then A[0..WIDTH-1], LSB first;
  - then B[0..WIDTH-1], LSB first.
- Output frame:
  - start bit 1;
  - then P[0..2·WIDTH-1], LSB first;
  - then `tx` returns to 0.
- FSM states:
  - IDLE: `rx`=1 sampled → RECV, bit counter cleared. `rx`=0 → stay.
  - RECV: each edge shifts `rx` into the operand register (first WIDTH bits → A, next WIDTH → B). After the 2·WIDTH-th data bit → MUL.
  - MUL: exactly WIDTH cycles of shift-add, one multiplier bit per cycle, accumulator 2·WIDTH bits wide.
    - SIGNED=1: operands are converted to magnitudes on entry. The product is negated (two's complement, 2·WIDTH bits) on the last MUL cycle if the operand signs differ.
    - The result is then latched into the output shift register → SEND.
  - SEND: 1 + 2·WIDTH cycles (start bit plus product bits) → IDLE.
- `rx` is ignored in MUL and SEND; no framing check is performed.
- Product is exact: no overflow is possible in 2·WIDTH bits for either mode. Signed minimum × minimum (e.g. −4×−4 = 16 at WIDTH=3) is representable.
- No state carries over between frames; the operand and accumulator registers are reloaded every frame.

## Timing
- Reset:
  - state = IDLE;
  - `tx`=0, `busy`=0, `done`=0;
  - counters and data registers cleared.
  - Reset asserted mid-frame in any state aborts the frame. On the next edge `tx` is 0 and no `done` pulse is issued.
- Edge numbering: E0 is the edge at which the start bit is sampled in IDLE.
- Data bits are sampled at E1..E2W (W = WIDTH). State = MUL after E2W.
- MUL occupies E2W+1..E3W; state = SEND after E3W.
- `tx`=1 (start bit) is registered at E3W+1. P[i] is registered at E3W+2+i for i = 0..2W−1.
- At E5W+2:
  - `tx`←0, state←IDLE, `done`←1 for one cycle;
  - total frame latency from E0 to `done` high is 5W+2 edges.
- `busy` rises at E0 and falls at E5W+2.
- Back-to-back frames: a start bit present on `rx` at E5W+2 is not accepted, because the state is still SEND at that edge. The earliest accepted start is at E5W+3, the cycle in which `done` is high.
- `rx` held at 1 continuously: the next frame's start bit is taken at E5W+3, with no minimum idle gap.

## Test plan
- WIDTH=3, SIGNED=0, `rx` = 1,1,0,1,1,1,0 (A=5, B=3) → `tx` = 1 then 1,1,1,1,0,0 (P=15 LSB first); `done` one cycle at E17.
- WIDTH=3, SIGNED=0, A=7, B=7 → P = 49 = 110001b, emitted as 1,0,0,0,1,1; A=0, B=6 → P emitted as six 0s after the start bit.
- WIDTH=3, SIGNED=1, A=−3 (101b), B=2 (010b) → P = −6 = 111010b, emitted as 0,1,0,1,1,1; A=−4, B=−4 → P = 16 = 010000b.
- Reset asserted in each of RECV, MUL and SEND → next cycle `tx`=0, `busy`=0, no `done`. A fresh frame afterwards yields the correct product.
- Two frames with `rx` start bit at E17+1 (5×3+3 = E18 for the second) → both products correct. A start bit offered at E17 is ignored and must not corrupt the frame.
- WIDTH=8, SIGNED=1, A=−128, B=127 → P = −16256 (0xC080) over 16 bits. WIDTH=8, SIGNED=0, A=255, B=255 → P = 0xFE01.
